// File: rtl/act_fill_ctrl_pkg.sv
// act_fill_ctrl shared types: FSM encoding and default beat geometry.
// Beat width is derived from the activation array write width.
package act_fill_ctrl_pkg;

  localparam int ARR_WR_WIDTH = 128;
  localparam int ACT_DW       = 8;
  localparam int ACT_WR_NUM   = ARR_WR_WIDTH / ACT_DW;
  localparam int ACT_SRAM_AW  = 12;
  localparam int ACT_CNT_W    = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_PUSH = 3'd3,
    ST_DONE = 3'd4
  } fill_state_e;

endpackage

// File: rtl/act_fill_ctrl_if.sv
// SRAM read port plus activation array write side.
// master = fill controller, slave = memory/array side.
interface act_fill_ctrl_if
  import act_fill_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = ACT_DW,
  parameter int WR_NUM          = ACT_WR_NUM,
  parameter int SRAM_ADDR_WIDTH = ACT_SRAM_AW
);

  logic                         sram_rd_en;
  logic [SRAM_ADDR_WIDTH-1:0]   sram_rd_addr;
  logic                         sram_rd_val;
  logic [DATA_WIDTH*WR_NUM-1:0] sram_rd_data;
  logic                         datain_rdy;
  logic                         datain_val;
  logic [DATA_WIDTH*WR_NUM-1:0] datain;

  modport master (
    output sram_rd_en,
    output sram_rd_addr,
    input  sram_rd_val,
    input  sram_rd_data,
    input  datain_rdy,
    output datain_val,
    output datain
  );

  modport slave (
    input  sram_rd_en,
    input  sram_rd_addr,
    output sram_rd_val,
    output sram_rd_data,
    output datain_rdy,
    input  datain_val,
    input  datain
  );

endinterface

// File: rtl/act_fill_ctrl.sv
// Activation fill sequencer: SRAM line reads -> array write beats.
// One read outstanding; each beat issued only while the array is ready.
module act_fill_ctrl
  import act_fill_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = ACT_DW,
  parameter int WR_NUM          = ACT_WR_NUM,
  parameter int SRAM_ADDR_WIDTH = ACT_SRAM_AW,
  parameter int CNT_WIDTH       = ACT_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       reset,
  input  logic                       cfg_start,
  input  logic [SRAM_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [CNT_WIDTH-1:0]       cfg_num_beats,
  act_fill_ctrl_if.master            bus,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_WIDTH-1:0]       beat_cnt
);

  localparam int BW = DATA_WIDTH * WR_NUM;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  fill_state_e state_q, state_d;

  logic [SRAM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0]       num_q, num_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]              data_q, data_d;
  logic                       val_q, val_d;

  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 start_acc;
  logic                 last_beat;

  assign cnt_inc   = cnt_q + CNT_ONE;
  assign start_acc = (state_q == ST_IDLE) && cfg_start;
  assign last_beat = (cnt_inc == num_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d = (cfg_num_beats == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.datain_rdy) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.sram_rd_val) state_d = ST_PUSH;
      end
      ST_PUSH: begin
        state_d = last_beat ? ST_DONE : ST_REQ;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (reset) state_d = ST_IDLE;
  end

  // Read data returning outside WAIT (e.g. after a soft reset) is dropped.
  always_comb begin
    base_d = base_q;
    num_d  = num_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    if (start_acc) begin
      base_d = cfg_base_addr;
      num_d  = cfg_num_beats;
      cnt_d  = '0;
    end
    if (state_q == ST_WAIT && bus.sram_rd_val) begin
      data_d = bus.sram_rd_data;
    end
    if (state_q == ST_PUSH) begin
      cnt_d = cnt_inc;
    end
    if (reset) begin
      base_d = '0;
      num_d  = '0;
      cnt_d  = '0;
    end
  end

  assign val_d = (state_d == ST_PUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      num_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      val_q  <= 1'b0;
    end else begin
      base_q <= base_d;
      num_q  <= num_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      val_q  <= val_d;
    end
  end

  always_comb begin
    bus.sram_rd_en   = 1'b0;
    bus.sram_rd_addr = base_q + SRAM_ADDR_WIDTH'(cnt_q);
    bus.datain_val   = val_q;
    bus.datain       = data_q;
    busy             = 1'b0;
    done             = 1'b0;
    beat_cnt         = cnt_q;
    unique case (1'b1)
      (state_q == ST_REQ): begin
        bus.sram_rd_en = bus.datain_rdy;
        busy           = 1'b1;
      end
      (state_q == ST_WAIT),
      (state_q == ST_PUSH): busy = 1'b1;
      (state_q == ST_DONE): begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_act_fill_ctrl.sv
// Scoreboard bench for act_fill_ctrl with an SRAM/array model.
// Expected reads, beats and done events are queued at start time.
module tb_act_fill_ctrl;
  import act_fill_ctrl_pkg::*;

  localparam int DW = 8;
  localparam int WN = 16;
  localparam int AW = 12;
  localparam int CW = 12;
  localparam int BW = DW * WN;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [CW-1:0] cfg_num = '0;
  logic          busy;
  logic          done;
  logic [CW-1:0] beat_cnt;

  logic rdy_en = 1'b0;
  bit   rand_rdy = 1'b0;
  int   lat = 1;

  act_fill_ctrl_if #(
    .DATA_WIDTH(DW), .WR_NUM(WN), .SRAM_ADDR_WIDTH(AW)
  ) bus ();

  assign bus.datain_rdy = rdy_en & ~bus.datain_val;

  act_fill_ctrl #(
    .DATA_WIDTH(DW), .WR_NUM(WN),
    .SRAM_ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .reset(reset),
    .cfg_start(cfg_start),
    .cfg_base_addr(cfg_base),
    .cfg_num_beats(cfg_num),
    .bus(bus),
    .busy(busy),
    .done(done),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [BW-1:0] act, logic [BW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  logic [BW-1:0] mem [1<<AW];
  logic [AW-1:0] exp_addr[$];
  logic [BW-1:0] exp_data[$];
  int            exp_done[$];

  int done_cnt = 0;
  int done_tgt = 0;
  int nreq = 0;
  int start_cyc = 0;
  int first_req_cyc = -1;
  int push_idx = 0;
  bit prev_val = 1'b0;

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.sram_rd_en) begin
        nreq++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
        chk("req_needs_rdy", bus.datain_rdy, 1);
        if (exp_addr.size() == 0) chk("unexpected_req", 1, 0);
        else chk("rd_addr", bus.sram_rd_addr, exp_addr.pop_front());
      end
      if (bus.datain_val) begin
        chk("beat_cnt_at_push", beat_cnt, push_idx);
        push_idx++;
        if (exp_data.size() == 0) chk("unexpected_val", 1, 0);
        else chk("datain", bus.datain, exp_data.pop_front());
      end
      if (done) begin
        int n;
        done_cnt++;
        chk("busy_in_done", busy, 1);
        if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          n = exp_done.pop_front();
          chk("beat_cnt_at_done", beat_cnt, n);
          if (n == 0) chk("zero_done_lat", cyc - start_cyc, 1);
          else chk("done_after_last", prev_val, 1);
        end
      end
      prev_val = bus.datain_val;
    end
  end

  // SRAM model: one outstanding read, latency in cycles
  int pend = 0;
  logic [AW-1:0] paddr;

  always @(negedge clk) begin
    if (rst_n && bus.sram_rd_en) begin
      pend = lat;
      paddr = bus.sram_rd_addr;
    end
  end

  initial begin
    bus.sram_rd_val = 1'b0;
    bus.sram_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.sram_rd_val = 1'b0;
      bus.sram_rd_data = {$urandom, $urandom, $urandom, $urandom};
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.sram_rd_val = 1'b1;
          bus.sram_rd_data = mem[paddr];
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) rdy_en = ($urandom_range(0, 3) != 0);
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue_start(logic [AW-1:0] base, int n, bit rec = 1'b1);
    logic [AW-1:0] a;
    cfg_start = 1'b1;
    cfg_base = base;
    cfg_num = CW'(n);
    if (rec) begin
      for (int i = 0; i < n; i++) begin
        a = base + AW'(i);
        exp_addr.push_back(a);
        exp_data.push_back(mem[a]);
      end
      exp_done.push_back(n);
      done_tgt = done_cnt + 1;
      start_cyc = cyc;
      first_req_cyc = -1;
      push_idx = 0;
    end
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt < done_tgt && t < 400) begin
      tick();
      t++;
    end
    chk("done_seen", done_cnt >= done_tgt, 1);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: no summary within time limit");
    $fatal(1);
  end

  initial begin
    int n0;
    int t;
    int rise;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    tick(3);
    rst_n = 1'b1;
    tick();

    chk("rst_rd_en", bus.sram_rd_en, 0);
    chk("rst_rd_addr", bus.sram_rd_addr, 0);
    chk("rst_val", bus.datain_val, 0);
    chk("rst_datain", bus.datain, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_beat_cnt", beat_cnt, 0);

    // basic
    rdy_en = 1'b1;
    lat = 1;
    issue_start(12'h010, 3);
    wait_done();

    // backpressure
    rdy_en = 1'b0;
    issue_start(12'h020, 2);
    tick(5);
    rdy_en = 1'b1;
    rise = cyc;
    wait_done();
    chk("bp_first_req", first_req_cyc, rise);

    // wrap
    issue_start(12'hFFF, 2);
    wait_done();

    // zero length
    chk("zero_idle_busy", busy, 0);
    issue_start(12'h055, 0);
    wait_done();

    // soft reset while waiting on a read
    lat = 2;
    n0 = nreq;
    issue_start(12'h200, 2);
    t = 0;
    while (nreq == n0 && t < 50) begin
      tick();
      t++;
    end
    chk("rst_req_seen", nreq > n0, 1);
    reset = 1'b1;
    exp_addr.delete();
    exp_data.delete();
    exp_done.delete();
    tick();
    reset = 1'b0;
    chk("softrst_busy", busy, 0);
    chk("softrst_beat_cnt", beat_cnt, 0);
    chk("softrst_val", bus.datain_val, 0);
    tick(4);
    lat = 1;
    issue_start(12'h300, 2);
    wait_done();

    // ignored start, slow SRAM
    lat = 3;
    issue_start(12'h100, 3);
    tick(2);
    issue_start(12'h400, 5, 1'b0);
    wait_done();

    // random
    rand_rdy = 1'b1;
    for (int k = 0; k < 25; k++) begin
      lat = $urandom_range(1, 4);
      issue_start(AW'($urandom), $urandom_range(0, 6));
      wait_done();
    end
    rand_rdy = 1'b0;
    tick(3);
    chk("queues_empty",
        exp_addr.size() + exp_data.size() + exp_done.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/act_fill_ctrl.md
Name: act_fill_ctrl

Overview:
- Sequencer between the activation SRAM read port and the write side of the per-PE activation register array.
- Once started with a base address and a beat count, it fetches one WR_NUM-word row slice per beat from SRAM, but only while the array signals datain_rdy.
- It delivers each slice as a single-cycle datain_val pulse, and signals done when the last beat has been written.
- It provides all write-side sequencing of the activation register array.

Parameters:
- DATA_WIDTH, 8, bits per activation word
- WR_NUM, 16, words per beat (array write width / DATA_WIDTH)
- SRAM_ADDR_WIDTH, 12, SRAM word-line address width (one line = one beat)
- CNT_WIDTH, 12, width of beat count and counters

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- reset  in  1  synchronous soft reset (layer/row restart)
- cfg_start  in  1  one-cycle start pulse; accepted only in IDLE
- cfg_base_addr  in  SRAM_ADDR_WIDTH  first SRAM line, sampled on accepted start
- cfg_num_beats  in  CNT_WIDTH  beats to transfer, sampled on accepted start
- sram_rd_en  out  1  SRAM read request, one-cycle pulse
- sram_rd_addr  out  SRAM_ADDR_WIDTH  read address, valid with sram_rd_en
- sram_rd_val  in  1  read data valid (returns >=1 cycle after sram_rd_en)
- sram_rd_data  in  DATA_WIDTH*WR_NUM  read data
- datain_rdy  in  1  array can accept a beat
- datain_val  out  1  write strobe to array, one-cycle pulse, registered
- datain  out  DATA_WIDTH*WR_NUM  write data, registered, valid with datain_val
- busy  out  1  high from the cycle after an accepted start through the DONE state
- done  out  1  one-cycle pulse after the final beat
- beat_cnt  out  CNT_WIDTH  beats written since start

Behaviour:
- rst_n low: state=IDLE; all outputs 0; internal address/count registers 0; datain holding register 0.
- reset high (synchronous, priority over everything except rst_n):
  - Next state IDLE; counters 0; datain_val/sram_rd_en/done 0 next cycle.
  - A read outstanding at reset is discarded: sram_rd_val is ignored in IDLE and DONE.
- States IDLE, REQ, WAIT, PUSH, DONE.
- IDLE:
  - On cfg_start, latch base and count, and set beat_cnt=0.
  - If cfg_num_beats==0, go to DONE; otherwise go to REQ.
  - cfg_start in any other state is ignored.
- REQ:
  - If datain_rdy=1, assert sram_rd_en for one cycle with sram_rd_addr = base+beat_cnt (modulo 2^SRAM_ADDR_WIDTH, wrap allowed), then go to WAIT.
  - If datain_rdy=0, stay in REQ with no request.
- WAIT: on sram_rd_val, capture sram_rd_data into the datain register and go to PUSH; otherwise stay.
- PUSH:
  - datain_val=1 for exactly this cycle; beat_cnt increments at the end of the cycle.
  - If beat_cnt+1==num_beats, go to DONE; otherwise go to REQ.
- DONE: done=1 for one cycle, then IDLE. busy is 1 in REQ/WAIT/PUSH/DONE.
- At most one read is outstanding. The array drops datain_rdy in the cycle datain_val is high, so REQ never issues in the same cycle as PUSH. Minimum beat period is 3 cycles with 1-cycle SRAM latency.
- datain_rdy may drop while in WAIT. The fetched beat is still pushed, because the array accepts any datain_val.
- sram_rd_val outside WAIT has no effect.
- Latency: start → first sram_rd_en = 1 cycle when datain_rdy=1.

Decomposition:
- Shared package / include: state encoding localparams (IDLE=0, REQ=1, WAIT=2, PUSH=3, DONE=4, 3-bit) and the default DATA_WIDTH/WR_NUM derived from the existing array write-width macros.
- No sub-module; single FSM plus counters.

Test Plan:
- Basic: base=0x010, beats=3, datain_rdy=1, SRAM latency 1 → sram_rd_addr 0x010,0x011,0x012; three datain_val pulses with matching data; done one cycle after the third pulse; beat_cnt=3.
- Backpressure: beats=2; hold datain_rdy=0 for 5 cycles after start → no sram_rd_en while low; first request the cycle rdy rises; both beats delivered.
- Wrap: base=0xFFF, beats=2 → addresses 0xFFF then 0x000.
- Zero length: beats=0 → no sram_rd_en or datain_val; done pulses the cycle after start; busy high only in DONE.
- Reset mid-op: assert reset in WAIT, then deliver sram_rd_val the next cycle → no datain_val; state IDLE; beat_cnt=0; a new start works normally.
- Ignored start and variable latency: pulse cfg_start while busy, and use SRAM latency 3 → the second start has no effect; each beat is pushed exactly once after its sram_rd_val.
